// File: rtl/vec_mem_requester_pkg.sv
//==============================================================================
// Module      : vec_mem_pkg
// Description : Shared types and geometry for the vector memory requester:
//               command opcodes, sequencer states and address widths.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package vec_mem_pkg;

    localparam int LANES       = 4;
    localparam int LANE_W      = 2;
    localparam int BYTE_ADDR_W = 19;
    localparam int WORD_ADDR_W = 17;
    localparam int DATA_W      = 32;

    // Command opcodes as encoded on the request port
    typedef enum logic [1:0] {
        OP_LDW     = 2'b00,
        OP_STW     = 2'b01,
        OP_GATHER  = 2'b10,
        OP_SCATTER = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LDW   = 3'd1,
        ST_STW   = 3'd2,
        ST_GATH  = 3'd3,
        ST_SC_RD = 3'd4,
        ST_SC_WR = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

endpackage : vec_mem_pkg

`default_nettype wire

// File: rtl/vec_mem_requester_lane_addr_gen.sv
//==============================================================================
// Module      : vec_lane_addr_gen
// Description : Byte address of lane N of a strided access:
//               base + N * sext(stride), N = 0..3, wrapping modulo 2^19.
//               The multiply by 0..3 is a shift plus an add.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module vec_lane_addr_gen
    import vec_mem_pkg::*;
#(
    parameter int STRIDE_W = 8
) (
    input  logic [BYTE_ADDR_W-1:0] base_i,
    input  logic [STRIDE_W-1:0]    stride_i,
    input  logic [LANE_W-1:0]      lane_i,
    output logic [BYTE_ADDR_W-1:0] addr_o
);

    logic [BYTE_ADDR_W-1:0] sext;
    logic [BYTE_ADDR_W-1:0] offset;

    generate
        if (STRIDE_W >= BYTE_ADDR_W) begin : g_sext_trunc
            assign sext = stride_i[BYTE_ADDR_W-1:0];
        end else begin : g_sext_ext
            assign sext = {{(BYTE_ADDR_W-STRIDE_W){stride_i[STRIDE_W-1]}}, stride_i};
        end
    endgenerate

    // Lane offset = lane * stride, built from shifts so no multiplier is needed
    always_comb begin
        offset = '0;
        case (lane_i)
            2'd0:    offset = '0;
            2'd1:    offset = sext;
            2'd2:    offset = sext << 1;
            2'd3:    offset = (sext << 1) + sext;
            default: offset = '0;
        endcase
    end

    assign addr_o = base_i + offset;

endmodule : vec_lane_addr_gen

`default_nettype wire

// File: rtl/vec_mem_requester.sv
//==============================================================================
// Module      : vec_mem_requester
// Description : Sequencer for the vector data memory port. Takes one
//               LDW/STW/GATHER/SCATTER command at a time, drives the memory
//               pins cycle by cycle and returns a one-cycle response pulse.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module vec_mem_requester
    import vec_mem_pkg::*;
#(
    parameter int STRIDE_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    // command port
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [BYTE_ADDR_W-1:0] req_addr_i,
    input  logic [STRIDE_W-1:0]    req_stride_i,
    input  logic [DATA_W-1:0]      req_data_i,
    // response port
    output logic                   rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_data_o,
    // memory port
    output logic [WORD_ADDR_W-1:0] mem_a_o,
    output logic [DATA_W-1:0]      mem_wdv_o,
    output logic [DATA_W-1:0]      mem_wds_o,
    output logic [LANE_W-1:0]      mem_pos_o,
    output logic                   mem_we_o,
    output logic                   mem_e_o,
    output logic                   mem_s_o,
    input  logic [DATA_W-1:0]      mem_rd_i
);

    state_e                 state_q,  state_d;
    logic [LANE_W-1:0]      lane_q,   lane_d;
    logic [BYTE_ADDR_W-1:0] addr_q,   addr_d;
    logic [STRIDE_W-1:0]    stride_q, stride_d;
    logic [DATA_W-1:0]      data_q,   data_d;
    logic [DATA_W-1:0]      result_q, result_d;
    logic [DATA_W-1:0]      wbuf_q,   wbuf_d;

    logic [BYTE_ADDR_W-1:0] lane_addr;

    vec_lane_addr_gen #(
        .STRIDE_W (STRIDE_W)
    ) u_lane_addr_gen (
        .base_i   (addr_q),
        .stride_i (stride_q),
        .lane_i   (lane_q),
        .addr_o   (lane_addr)
    );

    // State, lane counter and latched command/data registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            lane_q   <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            data_q   <= '0;
            result_q <= '0;
            wbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            data_q   <= data_d;
            result_q <= result_d;
            wbuf_q   <= wbuf_d;
        end
    end

    // Next state and memory/handshake outputs, decoded from the current state
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        data_d      = data_q;
        result_d    = result_q;
        wbuf_d      = wbuf_q;

        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        mem_a_o     = '0;
        mem_wdv_o   = '0;
        mem_wds_o   = '0;
        mem_pos_o   = '0;
        mem_we_o    = 1'b0;
        mem_e_o     = 1'b0;
        mem_s_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d   = req_addr_i;
                    stride_d = req_stride_i;
                    data_d   = req_data_i;
                    result_d = '0;
                    wbuf_d   = '0;
                    lane_d   = '0;
                    case (op_e'(req_op_i))
                        OP_LDW:     state_d = ST_LDW;
                        OP_STW:     state_d = ST_STW;
                        OP_GATHER:  state_d = ST_GATH;
                        OP_SCATTER: state_d = ST_SC_RD;
                    endcase
                end
            end

            ST_LDW: begin
                mem_a_o  = lane_addr[BYTE_ADDR_W-1:2];
                result_d = mem_rd_i;
                state_d  = ST_DONE;
            end

            ST_STW: begin
                mem_a_o   = lane_addr[BYTE_ADDR_W-1:2];
                mem_wdv_o = data_q;
                mem_we_o  = 1'b1;
                state_d   = ST_DONE;
            end

            ST_GATH: begin
                mem_a_o   = lane_addr[BYTE_ADDR_W-1:2];
                mem_pos_o = lane_addr[1:0];
                mem_e_o   = 1'b1;
                mem_s_o   = 1'b1;
                result_d[{lane_q, 3'b000} +: 8] = mem_rd_i[7:0];
                if (lane_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    lane_d = lane_q + 2'd1;
                end
            end

            // Each scatter lane re-reads its word, so overlapping lanes merge
            // correctly and the last lane to touch a byte wins.
            ST_SC_RD: begin
                mem_a_o = lane_addr[BYTE_ADDR_W-1:2];
                wbuf_d  = mem_rd_i;
                state_d = ST_SC_WR;
            end

            ST_SC_WR: begin
                mem_a_o   = lane_addr[BYTE_ADDR_W-1:2];
                mem_wdv_o = wbuf_q;
                mem_wds_o = {24'd0, data_q[{lane_q, 3'b000} +: 8]};
                mem_pos_o = lane_addr[1:0];
                mem_e_o   = 1'b1;
                mem_we_o  = 1'b1;
                if (lane_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    lane_d  = lane_q + 2'd1;
                    state_d = ST_SC_RD;
                end
            end

            // Stores leave result_q at the zero loaded on acceptance
            ST_DONE: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = result_q;
                lane_d      = '0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule : vec_mem_requester

`default_nettype wire

// File: tb/tb_vec_mem_requester.sv
//==============================================================================
// Module      : tb_vec_mem_requester
// Description : Directed bench for vec_mem_requester with a behavioural
//               lane-capable memory and a response scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vec_mem_requester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [18:0] req_addr = '0;
    logic [7:0]  req_stride = '0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [16:0] mem_a;
    logic [31:0] mem_wdv;
    logic [31:0] mem_wds;
    logic [1:0]  mem_pos;
    logic        mem_we;
    logic        mem_e;
    logic        mem_s;
    logic [31:0] mem_rd;

    // bench-side preload port into the memory model
    logic        pre_we = 1'b0;
    logic [16:0] pre_a  = '0;
    logic [31:0] pre_d  = '0;

    logic [31:0] mem [0:131071];

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] exp_q [$];
    int          cyc;
    logic [1:0]  tr_pos [0:15];
    logic [16:0] tr_a   [0:15];
    logic [31:0] tr_wdv [0:15];
    logic [15:0] we_bits;

    always #5 clk = ~clk;

    vec_mem_requester #(.STRIDE_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_addr_i   (req_addr),
        .req_stride_i (req_stride),
        .req_data_i   (req_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .mem_a_o      (mem_a),
        .mem_wdv_o    (mem_wdv),
        .mem_wds_o    (mem_wds),
        .mem_pos_o    (mem_pos),
        .mem_we_o     (mem_we),
        .mem_e_o      (mem_e),
        .mem_s_o      (mem_s),
        .mem_rd_i     (mem_rd)
    );

    // Combinational read: lane extract returns the selected byte in [7:0]
    always_comb begin
        logic [31:0] w;
        w = mem[mem_a];
        if (mem_e && mem_s && !mem_we) mem_rd = {24'd0, w[{mem_pos, 3'b000} +: 8]};
        else                            mem_rd = w;
    end

    // Writes: lane mode writes WDV with lane POS replaced by WDS[7:0]
    always @(posedge clk) begin
        logic [31:0] merged;
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (mem_we) begin
            merged = mem_wdv;
            if (mem_e) merged[{mem_pos, 3'b000} +: 8] = mem_wds[7:0];
            mem[mem_a] <= merged;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [16:0] a, input logic [31:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Issue one command, trace memory pins until the response, check it
    task automatic issue(input string tag, input logic [1:0] op, input logic [18:0] addr,
                         input logic [7:0] stride, input logic [31:0] data,
                         input logic [31:0] exp, input int lat);
        bit busy_ok;
        logic [31:0] want;
        check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_op     = op;
        req_addr   = addr;
        req_stride = stride;
        req_data   = data;
        req_valid  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        // scramble request inputs: the DUT must work from its latched copy
        req_valid  = 1'b0;
        req_op     = 2'($urandom);
        req_addr   = 19'($urandom);
        req_stride = 8'($urandom);
        req_data   = $urandom;
        cyc     = 0;
        busy_ok = 1'b1;
        we_bits = '0;
        while (rsp_valid !== 1'b1 && cyc < 24) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            if (cyc < 16) begin
                tr_pos[cyc]  = mem_pos;
                tr_a[cyc]    = mem_a;
                tr_wdv[cyc]  = mem_wdv;
                we_bits[cyc] = mem_we;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (req_ready !== 1'b0) busy_ok = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(lat - 1));
        check({tag, "_ready_busy"}, {31'd0, busy_ok}, 32'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        check({tag, "_rsp_data"}, rsp_data, want);
        @(posedge clk); #1;
        check({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",     {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data",  rsp_data, 32'd0);
        check("rst_mem_ctl",   {26'd0, mem_we, mem_e, mem_s, mem_pos, 1'b0}, 32'd0);
        check("rst_mem_a",     {15'd0, mem_a}, 32'd0);
        check("rst_mem_wd",    mem_wdv | mem_wds, 32'd0);

        preload(17'd4, 32'hA1B2C3D4);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- LDW ----------------
        issue("ldw", 2'b00, 19'h00010, 8'h00, 32'h0, 32'hA1B2C3D4, 2);
        check("ldw_mem_a", {15'd0, tr_a[0]}, 32'd4);

        // ---------------- STW + readback ----------------
        issue("stw", 2'b01, 19'h00020, 8'h00, 32'hDEADBEEF, 32'h0, 2);
        check("stw_mem_a", {15'd0, tr_a[0]}, 32'd8);
        check("stw_we",    {16'd0, we_bits}, 32'h1);
        check("stw_wdv",   tr_wdv[0], 32'hDEADBEEF);
        issue("stw_rb", 2'b00, 19'h00020, 8'h00, 32'h0, 32'hDEADBEEF, 2);

        // ---------------- GATHER +5 ----------------
        preload(17'd0, 32'hAABB11CC);
        preload(17'd1, 32'hDD22EEFF);
        preload(17'd2, 32'h33998877);
        preload(17'd4, 32'h55667744);
        issue("gath", 2'b10, 19'h00001, 8'h05, 32'h0, 32'h44332211, 5);
        check("gath_pos", {24'd0, tr_pos[3], tr_pos[2], tr_pos[1], tr_pos[0]},
              {24'd0, 2'd0, 2'd3, 2'd2, 2'd1});
        check("gath_a3", {15'd0, tr_a[3]}, 32'd4);

        // ---------------- GATHER -1 ----------------
        preload(17'h40, 32'h0D0C0B0A);
        issue("gath_neg", 2'b10, 19'h00103, 8'hFF, 32'h0, 32'h0A0B0C0D, 5);

        // ---------------- SCATTER with address wrap ----------------
        preload(17'h1FFFF, 32'h99887766);
        preload(17'h00000, 32'h55443322);
        issue("scat", 2'b11, 19'h7FFFE, 8'h01, 32'h04030201, 32'h0, 9);
        check("scat_we_seq", {16'd0, we_bits}, 32'h00AA);
        check("scat_word_top", mem[17'h1FFFF], 32'h02017766);
        check("scat_word_0",   mem[17'h00000], 32'h55440403);
        check("scat_word_1",   mem[17'h00001], 32'hDD22EEFF);
        issue("scat_rb_top", 2'b00, 19'h7FFFC, 8'h00, 32'h0, 32'h02017766, 2);
        issue("scat_rb_0",   2'b00, 19'h00000, 8'h00, 32'h0, 32'h55440403, 2);

        // ---------------- reset during SCATTER lane 2 ----------------
        req_op     = 2'b11;
        req_addr   = 19'h00200;
        req_stride = 8'h04;
        req_data   = 32'hCAFEF00D;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_scat_a", {15'd0, mem_a}, 32'h82);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_ready",     {31'd0, req_ready}, 32'd1);
        check("mrst_rsp",       {31'd0, rsp_valid} | rsp_data, 32'd0);
        check("mrst_mem_ctl",   {26'd0, mem_we, mem_e, mem_s, mem_pos, 1'b0}, 32'd0);
        check("mrst_mem_a",     {15'd0, mem_a}, 32'd0);
        #1;
        rst = 1'b0;
        issue("post_rst_ldw", 2'b00, 19'h00010, 8'h00, 32'h0, 32'h55667744, 2);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_vec_mem_requester

`default_nettype wire
